// File: rtl/regfile_mp.sv
// Multi-port register file with two write ports, NREAD combinational read ports,
// optional same-cycle write forwarding and a sequenced clear after reset or on request.
//
// state   | meaning
// CLEAR   | zeroing one entry per cycle at idx; writes ignored, reads return 0
// READY   | normal operation; writes accepted, ready=1
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int ADDR_W   = 5,
  parameter int NREAD    = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we0,
  input  logic [ADDR_W-1:0]       wa0,
  input  logic [XLEN-1:0]         wd0,
  input  logic                    we1,
  input  logic [ADDR_W-1:0]       wa1,
  input  logic [XLEN-1:0]         wd1,
  input  logic [NREAD*ADDR_W-1:0] ra,
  output logic [NREAD*XLEN-1:0]   rdata,
  output logic                    ready,
  input  logic                    clr
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {S_CLEAR, S_READY} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] idx, idx_next;
  logic [XLEN-1:0]   mem [DEPTH];

  logic wr0_ok, wr1_ok;
  assign wr0_ok = we0 && !((ZERO_REG != 0) && (wa0 == '0));
  assign wr1_ok = we1 && !((ZERO_REG != 0) && (wa1 == '0));

  always_comb begin
    state_next = state;
    idx_next   = idx;
    case (state)
      S_CLEAR: begin
        // idx holds at its last value on exit; only the clr reload moves it back to 0
        if (idx == {ADDR_W{1'b1}}) begin
          state_next = S_READY;
        end else begin
          idx_next = idx + ADDR_W'(1);
        end
      end
      S_READY: begin
        if (clr) begin
          state_next = S_CLEAR;
          idx_next   = '0;
        end
      end
      default: begin
        state_next = S_CLEAR;
        idx_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_CLEAR;
      idx   <= '0;
      ready <= 1'b0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      ready <= (state_next == S_READY);
    end
  end

  // Entry contents have no reset; the clear sequence zeroes them. Port 1 is written last so it wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (state == S_CLEAR) begin
        mem[idx] <= '0;
      end else begin
        if (wr0_ok) mem[wa0] <= wd0;
        if (wr1_ok) mem[wa1] <= wd1;
      end
    end
  end

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [XLEN-1:0]   val;
    assign addr = ra[k*ADDR_W +: ADDR_W];

    always_comb begin
      val = mem[addr];
      if (state != S_READY) begin
        val = '0;
      end else if ((ZERO_REG != 0) && (addr == '0)) begin
        val = '0;
      end else if ((BYPASS != 0) && we1 && (wa1 == addr)) begin
        val = wd1;
      end else if ((BYPASS != 0) && we0 && (wa0 == addr)) begin
        val = wd0;
      end
    end

    assign rdata[k*XLEN +: XLEN] = val;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a forwarding/zero-reg instance and a plain instance share stimulus,
// checked against hand-written vectors and a behavioural array model.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst, we0, we1, clr;
  logic [4:0]  wa0, wa1, ra0, ra1;
  logic [31:0] wd0, wd1;
  logic [63:0] rdata_a, rdata_b;
  logic        ready_a, ready_b;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] mdl [2][32];
  int          clear_left;

  always #5 clk = ~clk;

  regfile_mp #(.XLEN(32), .ADDR_W(5), .NREAD(2), .BYPASS(1), .ZERO_REG(1)) dut_a (
    .clk(clk), .rst(rst), .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .ra({ra1, ra0}), .rdata(rdata_a), .ready(ready_a), .clr(clr));

  regfile_mp #(.XLEN(32), .ADDR_W(5), .NREAD(2), .BYPASS(0), .ZERO_REG(0)) dut_b (
    .clk(clk), .rst(rst), .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .ra({ra1, ra0}), .rdata(rdata_b), .ready(ready_b), .clr(clr));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Instance 0 forwards and hardwires entry 0; instance 1 does neither.
  function automatic logic [31:0] exp_rd(input int i, input logic [4:0] a);
    if (clear_left > 0) return 32'h0;
    if (i == 0 && a == 5'd0) return 32'h0;
    if (i == 0 && we1 && wa1 == a) return wd1;
    if (i == 0 && we0 && wa0 == a) return wd0;
    return mdl[i][a];
  endfunction

  task automatic model_edge();
    if (!rst) begin
      clear_left = 32;
    end else if (clear_left > 0) begin
      clear_left--;
      if (clear_left == 0)
        for (int i = 0; i < 2; i++) for (int e = 0; e < 32; e++) mdl[i][e] = 32'h0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (we0 && !(i == 0 && wa0 == 5'd0)) mdl[i][wa0] = wd0;
        if (we1 && !(i == 0 && wa1 == 5'd0)) mdl[i][wa1] = wd1;
      end
      if (clr) clear_left = 32;
    end
  endtask

  task automatic step();
    @(negedge clk);
    chk("ready_a", {31'b0, ready_a}, {31'b0, clear_left == 0});
    chk("ready_b", {31'b0, ready_b}, {31'b0, clear_left == 0});
    chk("rd_a0", rdata_a[31:0],  exp_rd(0, ra0));
    chk("rd_a1", rdata_a[63:32], exp_rd(0, ra1));
    chk("rd_b0", rdata_b[31:0],  exp_rd(1, ra0));
    chk("rd_b1", rdata_b[63:32], exp_rd(1, ra1));
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    we0 = 0; we1 = 0; clr = 0;
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!ready_a && n < 100) begin
      step();
      n++;
    end
    chk(name, n, 32);
  endtask

  typedef struct {
    logic we0; logic [4:0] wa0; logic [31:0] wd0;
    logic we1; logic [4:0] wa1; logic [31:0] wd1;
    logic [4:0] ra0, ra1;
    logic [31:0] ea0, ea1, eb0, eb1;
  } vec_t;

  vec_t tbl[8];

  initial begin
    tbl[0] = '{1, 5,  32'hDEADBEEF, 0, 0,  32'h0,      5,  5,  32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        32'h0};
    tbl[1] = '{0, 0,  32'h0,        0, 0,  32'h0,      5,  6,  32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 32'h0};
    tbl[2] = '{1, 7,  32'h11111111, 1, 7,  32'h22222222, 7, 7, 32'h22222222, 32'h22222222, 32'h0,        32'h0};
    tbl[3] = '{0, 0,  32'h0,        0, 0,  32'h0,      7,  0,  32'h22222222, 32'h0,        32'h22222222, 32'h0};
    tbl[4] = '{0, 0,  32'h0,        1, 0,  32'hFFFFFFFF, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0};
    tbl[5] = '{0, 0,  32'h0,        0, 0,  32'h0,      0,  5,  32'h0,        32'hDEADBEEF, 32'hFFFFFFFF, 32'hDEADBEEF};
    tbl[6] = '{1, 31, 32'hCAFEF00D, 1, 30, 32'h12345678, 30, 31, 32'h12345678, 32'hCAFEF00D, 32'h0,      32'h0};
    tbl[7] = '{0, 0,  32'h0,        0, 0,  32'h0,      31, 30, 32'hCAFEF00D, 32'h12345678, 32'hCAFEF00D, 32'h12345678};

    rst = 0; clr = 0; we0 = 0; we1 = 0; wa0 = 0; wa1 = 0; wd0 = 0; wd1 = 0; ra0 = 0; ra1 = 0;
    clear_left = 32;
    repeat (2) @(posedge clk);
    #1;
    step();
    rst = 1;
    wait_ready("cycles_to_ready_after_reset");
    for (int a = 0; a < 32; a += 2) begin
      ra0 = 5'(a); ra1 = 5'(a + 1);
      step();
    end

    for (int v = 0; v < 8; v++) begin
      we0 = tbl[v].we0; wa0 = tbl[v].wa0; wd0 = tbl[v].wd0;
      we1 = tbl[v].we1; wa1 = tbl[v].wa1; wd1 = tbl[v].wd1;
      ra0 = tbl[v].ra0; ra1 = tbl[v].ra1;
      #1;
      chk($sformatf("vec%0d_a0", v), rdata_a[31:0],  tbl[v].ea0);
      chk($sformatf("vec%0d_a1", v), rdata_a[63:32], tbl[v].ea1);
      chk($sformatf("vec%0d_b0", v), rdata_b[31:0],  tbl[v].eb0);
      chk($sformatf("vec%0d_b1", v), rdata_b[63:32], tbl[v].eb1);
      step();
    end
    idle();

    we0 = 1; wa0 = 3; wd0 = 32'hA5A5A5A5; ra0 = 3; ra1 = 3;
    step();
    idle();
    clr = 1;
    step();
    clr = 0;
    for (int c = 0; c < 32; c++) begin
      we0 = 1'($urandom); wa0 = 5'($urandom_range(1, 7)); wd0 = $urandom;
      we1 = 1; wa1 = 3; wd1 = $urandom;
      ra0 = 3; ra1 = 5'($urandom);
      step();
      if (c < 31) chk("ready_low_during_clr", {31'b0, ready_a}, 32'h0);
    end
    idle();
    chk("ready_after_clr", {31'b0, ready_a}, 32'h1);
    ra0 = 3; ra1 = 3;
    #1;
    chk("entry3_after_clr_a", rdata_a[31:0], 32'h0);
    chk("entry3_after_clr_b", rdata_b[31:0], 32'h0);
    step();

    clr = 1;
    step();
    clr = 0;
    repeat (10) step();
    rst = 0; clr = 1;
    step();
    rst = 1; clr = 0;
    wait_ready("cycles_to_ready_after_midclear_reset");

    for (int c = 0; c < 600; c++) begin
      we0 = 1'($urandom); we1 = 1'($urandom);
      wa0 = 5'($urandom_range(0, 7)); wa1 = 5'($urandom_range(0, 7));
      wd0 = $urandom; wd1 = $urandom;
      ra0 = 5'($urandom_range(0, 7)); ra1 = 5'($urandom_range(0, 7));
      clr = ($urandom_range(0, 79) == 0);
      rst = ($urandom_range(0, 149) != 0);
      step();
    end
    idle();
    rst = 1;
    repeat (40) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
